// File: rtl/elevator_request_scheduler_if.sv
// Button/lamp and car-controller signals of the elevator request scheduler.
// master = environment (buttons + car controller), slave = scheduler.
interface elevator_request_scheduler_if #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = 2
);
    logic [NUM_FLOORS-1:0] hall_up;
    logic [NUM_FLOORS-1:0] hall_down;
    logic [NUM_FLOORS-1:0] cab_req;
    logic [FLOOR_W-1:0]    car_floor;
    logic                  car_arrived;
    logic                  tgt_ready;
    logic                  tgt_valid;
    logic [FLOOR_W-1:0]    tgt_floor;
    logic [1:0]            sweep_dir;
    logic [NUM_FLOORS-1:0] pend_lamps;
    logic                  fault;

    modport master (
        output hall_up, hall_down, cab_req, car_floor, car_arrived, tgt_ready,
        input  tgt_valid, tgt_floor, sweep_dir, pend_lamps, fault
    );

    modport slave (
        input  hall_up, hall_down, cab_req, car_floor, car_arrived, tgt_ready,
        output tgt_valid, tgt_floor, sweep_dir, pend_lamps, fault
    );
endinterface

// File: rtl/elevator_request_scheduler.sv
// SCAN-order elevator call scheduler: latches hall/cab calls, offers the next
// target floor over valid/ready, clears served calls on arrival, flags stuck cars.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS     = 4,
    parameter int FLOOR_W        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    elevator_request_scheduler_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            state;
    logic [NUM_FLOORS-1:0] pend_up, pend_down, pend_cab, pend_any, clr_mask;
    logic [NUM_FLOORS-1:0] up_next, down_next, cab_next;
    logic                  dir_down;
    logic [FLOOR_W-1:0]    tgt_q;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  fault_q;
    logic                  arrive_hit;

    logic                  here_hit, above_hit, below_hit;
    logic [FLOOR_W-1:0]    above_idx, below_idx, sel_floor;
    logic                  sel_down;

    assign pend_any   = pend_up | pend_down | pend_cab;
    assign arrive_hit = (state == S_WAIT) && bus.car_arrived && (bus.car_floor == tgt_q);

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            clr_mask[i] = arrive_hit && (FLOOR_W'(i) == tgt_q);
    end

    // Clear first, then OR in new pulses: a same-cycle re-request survives.
    assign up_next   = (pend_up   & ~clr_mask) | bus.hall_up;
    assign down_next = (pend_down & ~clr_mask) | bus.hall_down;
    assign cab_next  = (pend_cab  & ~clr_mask) | bus.cab_req;

    always_comb begin
        here_hit  = 1'b0;
        above_hit = 1'b0;
        below_hit = 1'b0;
        above_idx = '0;
        below_idx = '0;
        // Descending scan so the last match is the lowest floor above the car.
        for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (pend_any[i] && FLOOR_W'(i) > bus.car_floor) begin
                above_hit = 1'b1;
                above_idx = FLOOR_W'(i);
            end
        // Ascending scan so the last match is the highest floor below the car.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend_any[i] && FLOOR_W'(i) < bus.car_floor) begin
                below_hit = 1'b1;
                below_idx = FLOOR_W'(i);
            end
            if (pend_any[i] && FLOOR_W'(i) == bus.car_floor)
                here_hit = 1'b1;
        end
    end

    always_comb begin
        sel_floor = bus.car_floor;
        sel_down  = dir_down;
        if (!here_hit) begin
            if (!dir_down) begin
                sel_floor = above_hit ? above_idx : below_idx;
                sel_down  = !above_hit;
            end else begin
                sel_floor = below_hit ? below_idx : above_idx;
                sel_down  = below_hit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pend_up   <= '0;
            pend_down <= '0;
            pend_cab  <= '0;
            dir_down  <= 1'b0;
            tgt_q     <= '0;
            wait_cnt  <= '0;
            fault_q   <= 1'b0;
        end else begin
            pend_up   <= up_next;
            pend_down <= down_next;
            pend_cab  <= cab_next;
            case (state)
                S_IDLE: if (|pend_any) state <= S_SELECT;
                S_SELECT: begin
                    if (!(|pend_any)) begin
                        state <= S_IDLE;
                    end else begin
                        tgt_q    <= sel_floor;
                        dir_down <= sel_down;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.tgt_ready) begin
                        state    <= S_WAIT;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    if (arrive_hit) begin
                        wait_cnt <= '0;
                        state    <= (|(up_next | down_next | cab_next)) ? S_SELECT : S_IDLE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Car never arrived: flag it, keep calls, retry from IDLE.
                        wait_cnt <= '0;
                        fault_q  <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.tgt_valid  = (state == S_ISSUE);
    assign bus.tgt_floor  = tgt_q;
    assign bus.sweep_dir  = (state == S_IDLE) ? 2'b00 : (dir_down ? 2'b10 : 2'b01);
    assign bus.pend_lamps = pend_any;
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Randomized + directed bench for elevator_request_scheduler against a
// transaction-level model of pending calls and SCAN target choice.
module tb_elevator_request_scheduler;
    localparam int NF = 4;
    localparam int FW = 2;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    elevator_request_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus();

    elevator_request_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [NF-1:0] m_pend;
    logic          m_down;
    logic          m_fault;
    logic          m_clr;
    logic [FW-1:0] m_tgt;
    logic [FW-1:0] exp_tgt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Nearest pending floor in each direction, by distance from the car.
    function automatic void pick(input logic [NF-1:0] p, input int f, input logic d,
                                 output logic [FW-1:0] t, output logic nd);
        int up_t, dn_t;
        up_t = -1;
        dn_t = -1;
        for (int k = NF - 1; k >= 1; k--) begin
            if (f + k < NF && p[f + k]) up_t = f + k;
            if (f - k >= 0 && p[f - k]) dn_t = f - k;
        end
        if (p[f]) begin
            t = FW'(f); nd = d;
        end else if (!d) begin
            if (up_t >= 0) begin t = FW'(up_t); nd = 1'b0; end
            else           begin t = FW'(dn_t); nd = 1'b1; end
        end else begin
            if (dn_t >= 0) begin t = FW'(dn_t); nd = 1'b1; end
            else           begin t = FW'(up_t); nd = 1'b0; end
        end
    endfunction

    task automatic snapshot();
        logic nd;
        pick(m_pend, int'(bus.car_floor), m_down, exp_tgt, nd);
        m_down = nd;
    endtask

    task automatic noise_calls(input bit en);
        int fl;
        if (en && $urandom_range(0, 2) == 0) begin
            fl = $urandom_range(0, NF - 1);
            case ($urandom_range(0, 2))
                0:       bus.hall_up[fl]   = 1'b1;
                1:       bus.hall_down[fl] = 1'b1;
                default: bus.cab_req[fl]   = 1'b1;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_clr) m_pend = m_pend & ~(NF'(1) << m_tgt);
        m_pend = m_pend | bus.hall_up | bus.hall_down | bus.cab_req;
        m_clr = 1'b0;
        #1;
        bus.hall_up     = '0;
        bus.hall_down   = '0;
        bus.cab_req     = '0;
        bus.car_arrived = 1'b0;
        chk("lamps", 32'(bus.pend_lamps), 32'(m_pend));
        chk("fault", 32'(bus.fault), 32'(m_fault));
    endtask

    // Calls from IDLE: E0 latches them, E1 enters SELECT; model snapshot follows E1.
    task automatic start(input logic [NF-1:0] up, input logic [NF-1:0] dn, input logic [NF-1:0] cab);
        bus.hall_up   = up;
        bus.hall_down = dn;
        bus.cab_req   = cab;
        tick();
        tick();
        chk("select_dir", 32'(bus.sweep_dir), m_down ? 32'd2 : 32'd1);
        snapshot();
    endtask

    // Expects a snapshot just taken; DUT is about to leave SELECT.
    task automatic offer(input int hold, input bit noise);
        noise_calls(noise);
        tick();
        chk("valid", 32'(bus.tgt_valid), 32'd1);
        chk("tgt", 32'(bus.tgt_floor), 32'(exp_tgt));
        chk("dir", 32'(bus.sweep_dir), m_down ? 32'd2 : 32'd1);
        repeat (hold) begin
            noise_calls(noise);
            tick();
            chk("hold_valid", 32'(bus.tgt_valid), 32'd1);
            chk("hold_tgt", 32'(bus.tgt_floor), 32'(exp_tgt));
        end
        bus.tgt_ready = 1'b1;
        noise_calls(noise);
        tick();
        bus.tgt_ready = 1'b0;
        chk("acc_valid", 32'(bus.tgt_valid), 32'd0);
    endtask

    task automatic serve(input int hold, input int travel, input bit noise, input logic [NF-1:0] arr_up);
        offer(hold, noise);
        repeat (travel) begin
            noise_calls(noise);
            if (noise && $urandom_range(0, 2) == 0) begin
                bus.car_floor   = exp_tgt + FW'(1);
                bus.car_arrived = 1'b1;
            end
            tick();
            chk("wait_tgt", 32'(bus.tgt_floor), 32'(exp_tgt));
            chk("wait_valid", 32'(bus.tgt_valid), 32'd0);
        end
        bus.car_floor   = exp_tgt;
        bus.car_arrived = 1'b1;
        noise_calls(noise);
        bus.hall_up = bus.hall_up | arr_up;
        m_clr = 1'b1;
        m_tgt = exp_tgt;
        tick();
        if (m_pend == '0) begin
            chk("idle_dir", 32'(bus.sweep_dir), 32'd0);
        end else begin
            chk("sel_dir", 32'(bus.sweep_dir), m_down ? 32'd2 : 32'd1);
            snapshot();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        bus.hall_up = '0; bus.hall_down = '0; bus.cab_req = '0;
        bus.car_floor = '0; bus.car_arrived = 1'b0; bus.tgt_ready = 1'b0;
        m_pend = '0; m_down = 1'b0; m_fault = 1'b0; m_clr = 1'b0;
        m_tgt = '0; exp_tgt = '0;
        #12 rst_n = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.tgt_valid), 32'd0);
        chk("rst_tgt", 32'(bus.tgt_floor), 32'd0);
        chk("rst_dir", 32'(bus.sweep_dir), 32'd0);
        chk("rst_lamps", 32'(bus.pend_lamps), 32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);

        // Cab call to top floor from ground; target held under backpressure.
        start('0, '0, 4'b1000);
        chk("t1_tgt_model", 32'(exp_tgt), 32'd3);
        serve(5, 2, 1'b0, '0);

        // Sweep from floor 1 going up with calls at 0, 2, 3: expect 2, 3, 0.
        bus.car_floor = 2'd1;
        start('0, '0, 4'b1101);
        serve(0, 1, 1'b0, '0);
        serve(0, 1, 1'b0, '0);
        chk("t3_last_down", 32'(m_down), 32'd1);
        serve(0, 1, 1'b0, '0);

        // Call at the car's own floor; a re-request in the clearing cycle survives.
        bus.car_floor = 2'd2;
        start('0, 4'b0100, '0);
        serve(1, 0, 1'b0, 4'b0100);
        chk("set_wins", 32'(bus.pend_lamps[2]), 32'd1);
        serve(0, 0, 1'b0, '0);

        // Car never arrives: fault after the timeout, call kept and reissued.
        bus.car_floor = 2'd1;
        start('0, '0, 4'b1000);
        offer(0, 1'b0);
        repeat (TO - 1) tick();
        chk("to_wait_dir", 32'(bus.sweep_dir), 32'd1);
        m_fault = 1'b1;
        tick();
        chk("to_idle_dir", 32'(bus.sweep_dir), 32'd0);
        tick();
        snapshot();
        chk("to_reissue", 32'(exp_tgt), 32'd3);
        serve(0, 2, 1'b0, '0);

        // Random traffic with mid-flight calls and stray arrivals.
        for (int r = 0; r < 30; r++) begin
            if (m_pend == '0)
                start(NF'($urandom_range(0, 15)), NF'($urandom_range(0, 15)),
                      NF'($urandom_range(1, 15)));
            serve($urandom_range(0, 3), $urandom_range(0, 4), 1'b1, '0);
        end

        // Asynchronous reset while a target is on offer.
        if (m_pend == '0) start('0, '0, 4'b0001);
        noise_calls(1'b0);
        tick();
        chk("pre_rst_valid", 32'(bus.tgt_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.tgt_valid), 32'd0);
        chk("arst_lamps", 32'(bus.pend_lamps), 32'd0);
        chk("arst_fault", 32'(bus.fault), 32'd0);
        chk("arst_dir", 32'(bus.sweep_dir), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
